// File: rtl/id_ex_stage_if.sv
// ID -> EX bundle: the decoded ID-side fields and the registered EX-side copy.
// master drives id_* and observes ex_*; slave (the ID/EX register) does the reverse.
interface id_ex_stage_if #(
   parameter int CTRL_W = 8
);
   // ID side
   logic              id_valid;
   logic [31:0]       id_pc;
   logic [4:0]        id_rs_addr;
   logic [4:0]        id_rt_addr;
   logic [4:0]        id_rd_addr;
   logic              id_uses_rs;
   logic              id_uses_rt;
   logic [31:0]       id_rs_data;
   logic [31:0]       id_rt_data;
   logic [31:0]       id_imm;
   logic [CTRL_W-1:0] id_ctrl;
   logic              id_mem_read;
   logic              id_reg_write;

   // EX side
   logic              ex_valid;
   logic              ex_mem_read;
   logic              ex_reg_write;
   logic [31:0]       ex_pc;
   logic [31:0]       ex_rs_data;
   logic [31:0]       ex_rt_data;
   logic [31:0]       ex_imm;
   logic [4:0]        ex_rs_addr;
   logic [4:0]        ex_rt_addr;
   logic [4:0]        ex_rd_addr;
   logic [CTRL_W-1:0] ex_ctrl;

   modport master (
      output id_valid, id_pc, id_rs_addr, id_rt_addr, id_rd_addr,
      output id_uses_rs, id_uses_rt, id_rs_data, id_rt_data,
      output id_imm, id_ctrl, id_mem_read, id_reg_write,
      input  ex_valid, ex_mem_read, ex_reg_write, ex_pc,
      input  ex_rs_data, ex_rt_data, ex_imm,
      input  ex_rs_addr, ex_rt_addr, ex_rd_addr, ex_ctrl
   );

   modport slave (
      input  id_valid, id_pc, id_rs_addr, id_rt_addr, id_rd_addr,
      input  id_uses_rs, id_uses_rt, id_rs_data, id_rt_data,
      input  id_imm, id_ctrl, id_mem_read, id_reg_write,
      output ex_valid, ex_mem_read, ex_reg_write, ex_pc,
      output ex_rs_data, ex_rt_data, ex_imm,
      output ex_rs_addr, ex_rt_addr, ex_rd_addr, ex_ctrl
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and stall counter.
// Ports: clk, rst_n (sync, active-low); bus (id_ex_stage_if.slave: id_* in,
//   ex_* out); wb_reg_write/wb_rd_addr/wb_rd_data (write-back port);
//   flush, hold (in); stall (comb out); stall_cnt (saturating bubble count).
// Option: define WB_BYPASS_EN to forward same-cycle write-back data onto
//   the captured rs/rt values.
module id_ex_stage #(
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   id_ex_stage_if.slave     bus,
   input  logic             wb_reg_write,
   input  logic [4:0]       wb_rd_addr,
   input  logic [31:0]      wb_rd_data,
   input  logic             flush,
   input  logic             hold,
   output logic             stall,
   output logic [CNT_W-1:0] stall_cnt
);

   // Control half: cleared by bubbles and flushes.
   typedef struct packed {
      logic              valid;
      logic              memRead;
      logic              regWrite;
      logic [CTRL_W-1:0] ctrl;
   } exCtl_t;

   // Data half: only ever loaded or held, never cleared outside reset.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rsData;
      logic [31:0] rtData;
      logic [31:0] imm;
      logic [4:0]  rsAddr;
      logic [4:0]  rtAddr;
      logic [4:0]  rdAddr;
   } exDat_t;

   exCtl_t           ctlQ;
   exCtl_t           ctlD;
   exDat_t           datQ;
   exDat_t           datD;
   logic [CNT_W-1:0] cntQ;
   logic [CNT_W-1:0] cntD;

   logic             rsHit;
   logic             rtHit;
   logic             loadUse;
   logic [31:0]      rsCap;
   logic [31:0]      rtCap;

   // Hazard only against a real load in EX that writes a non-zero register.
   assign rsHit = bus.id_uses_rs &
                  (bus.id_rs_addr == datQ.rdAddr);
   assign rtHit = bus.id_uses_rt &
                  (bus.id_rt_addr == datQ.rdAddr);

   assign loadUse = bus.id_valid &
                    ctlQ.valid &
                    ctlQ.memRead &
                    (datQ.rdAddr != 5'd0) &
                    (rsHit | rtHit);

   // A flush discards the ID instruction, so there is nothing to freeze for.
   assign stall = ~flush & (hold | loadUse);

`ifdef WB_BYPASS_EN
   logic rsByp;
   logic rtByp;

   // The RF writes on the same edge we capture, so its read port still
   // shows the old value; take the write-back data directly instead.
   assign rsByp = wb_reg_write &
                  (wb_rd_addr != 5'd0) &
                  (wb_rd_addr == bus.id_rs_addr);
   assign rtByp = wb_reg_write &
                  (wb_rd_addr != 5'd0) &
                  (wb_rd_addr == bus.id_rt_addr);

   assign rsCap = rsByp ? wb_rd_data : bus.id_rs_data;
   assign rtCap = rtByp ? wb_rd_data : bus.id_rt_data;
`else
   logic unusedWb;

   assign unusedWb = ^{wb_reg_write, wb_rd_addr, wb_rd_data};
   assign rsCap    = bus.id_rs_data;
   assign rtCap    = bus.id_rt_data;
`endif

   always_comb begin
      ctlD = ctlQ;
      datD = datQ;
      cntD = cntQ;

      if (flush) begin
         ctlD = '0;
      end else if (hold) begin
         ctlD = ctlQ;
      end else if (loadUse) begin
         ctlD = '0;
         if (~&cntQ)
            cntD = cntQ + 1'b1;
      end else begin
         ctlD.valid    = bus.id_valid;
         ctlD.memRead  = bus.id_valid & bus.id_mem_read;
         ctlD.regWrite = bus.id_valid & bus.id_reg_write;
         ctlD.ctrl     = bus.id_valid ? bus.id_ctrl : '0;
         datD.pc       = bus.id_pc;
         datD.rsData   = rsCap;
         datD.rtData   = rtCap;
         datD.imm      = bus.id_imm;
         datD.rsAddr   = bus.id_rs_addr;
         datD.rtAddr   = bus.id_rt_addr;
         datD.rdAddr   = bus.id_rd_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctlQ <= '0;
         datQ <= '0;
         cntQ <= '0;
      end else begin
         ctlQ <= ctlD;
         datQ <= datD;
         cntQ <= cntD;
      end
   end

   assign bus.ex_valid     = ctlQ.valid;
   assign bus.ex_mem_read  = ctlQ.memRead;
   assign bus.ex_reg_write = ctlQ.regWrite;
   assign bus.ex_ctrl      = ctlQ.ctrl;
   assign bus.ex_pc        = datQ.pc;
   assign bus.ex_rs_data   = datQ.rsData;
   assign bus.ex_rt_data   = datQ.rtData;
   assign bus.ex_imm       = datQ.imm;
   assign bus.ex_rs_addr   = datQ.rsAddr;
   assign bus.ex_rt_addr   = datQ.rtAddr;
   assign bus.ex_rd_addr   = datQ.rdAddr;
   assign stall_cnt        = cntQ;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table plus multi-cycle
// sequences, with expected EX state queued at drive time.
module tb_id_ex_stage;

   localparam int CTRL_W = 8;
   localparam int CNT_W  = 4;

`ifdef WB_BYPASS_EN
   localparam logic [31:0] BYP_RT = 32'hDEADBEEF;
`else
   localparam logic [31:0] BYP_RT = 32'h0;
`endif

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic        uRs;
      logic        uRt;
      logic [31:0] rsD;
      logic [31:0] rtD;
      logic [31:0] imm;
      logic [7:0]  ctrl;
      logic        mr;
      logic        rw;
   } idIn_t;

   typedef struct {
      logic        stall;
      logic        v;
      logic        mr;
      logic        rw;
      logic [7:0]  ctrl;
      logic [31:0] pc;
      logic [31:0] rsD;
      logic [31:0] rtD;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [3:0]  cnt;
   } exp_t;

   typedef struct {
      idIn_t       id;
      logic        wbWe;
      logic [4:0]  wbA;
      logic [31:0] wbD;
      logic        fl;
      logic        ho;
      exp_t        e;
   } vec_t;

   logic             clk;
   logic             rst_n;
   logic             wb_reg_write;
   logic [4:0]       wb_rd_addr;
   logic [31:0]      wb_rd_data;
   logic             flush;
   logic             hold;
   logic             stall;
   logic [CNT_W-1:0] stall_cnt;

   id_ex_stage_if #(.CTRL_W(CTRL_W)) bus ();

   id_ex_stage #(
      .CTRL_W(CTRL_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .wb_reg_write(wb_reg_write),
      .wb_rd_addr  (wb_rd_addr),
      .wb_rd_data  (wb_rd_data),
      .flush       (flush),
      .hold        (hold),
      .stall       (stall),
      .stall_cnt   (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks;
   int   failures;
   exp_t sb[$];
   vec_t tbl[$];

   function automatic idIn_t mkIn(
      logic v, logic [31:0] pc, logic [4:0] rs, logic [4:0] rt,
      logic [4:0] rd, logic uRs, logic uRt, logic [31:0] rsD,
      logic [31:0] rtD, logic [31:0] imm, logic [7:0] ctrl,
      logic mr, logic rw);
      idIn_t x;
      x.valid = v;   x.pc = pc;   x.rs = rs;   x.rt = rt;
      x.rd = rd;     x.uRs = uRs; x.uRt = uRt; x.rsD = rsD;
      x.rtD = rtD;   x.imm = imm; x.ctrl = ctrl;
      x.mr = mr;     x.rw = rw;
      return x;
   endfunction

   function automatic exp_t mkExp(
      logic st, logic v, logic mr, logic rw, logic [7:0] ctrl,
      logic [31:0] pc, logic [31:0] rsD, logic [31:0] rtD,
      logic [31:0] imm, logic [4:0] rs, logic [4:0] rt,
      logic [4:0] rd, logic [3:0] cnt);
      exp_t e;
      e.stall = st;  e.v = v;     e.mr = mr;   e.rw = rw;
      e.ctrl = ctrl; e.pc = pc;   e.rsD = rsD; e.rtD = rtD;
      e.imm = imm;   e.rs = rs;   e.rt = rt;   e.rd = rd;
      e.cnt = cnt;
      return e;
   endfunction

   function automatic vec_t mkVec(
      idIn_t id, logic wbWe, logic [4:0] wbA, logic [31:0] wbD,
      logic fl, logic ho, exp_t e);
      vec_t x;
      x.id = id;   x.wbWe = wbWe; x.wbA = wbA; x.wbD = wbD;
      x.fl = fl;   x.ho = ho;     x.e = e;
      return x;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic drive(vec_t v);
      bus.id_valid     = v.id.valid;
      bus.id_pc        = v.id.pc;
      bus.id_rs_addr   = v.id.rs;
      bus.id_rt_addr   = v.id.rt;
      bus.id_rd_addr   = v.id.rd;
      bus.id_uses_rs   = v.id.uRs;
      bus.id_uses_rt   = v.id.uRt;
      bus.id_rs_data   = v.id.rsD;
      bus.id_rt_data   = v.id.rtD;
      bus.id_imm       = v.id.imm;
      bus.id_ctrl      = v.id.ctrl;
      bus.id_mem_read  = v.id.mr;
      bus.id_reg_write = v.id.rw;
      wb_reg_write     = v.wbWe;
      wb_rd_addr       = v.wbA;
      wb_rd_data       = v.wbD;
      flush            = v.fl;
      hold             = v.ho;
   endtask

   task automatic cmpEx(string nm, exp_t e);
      chk({nm, ".valid"}, {31'd0, bus.ex_valid}, {31'd0, e.v});
      chk({nm, ".memRd"}, {31'd0, bus.ex_mem_read}, {31'd0, e.mr});
      chk({nm, ".regWr"}, {31'd0, bus.ex_reg_write}, {31'd0, e.rw});
      chk({nm, ".ctrl"}, {24'd0, bus.ex_ctrl}, {24'd0, e.ctrl});
      chk({nm, ".pc"}, bus.ex_pc, e.pc);
      chk({nm, ".rsData"}, bus.ex_rs_data, e.rsD);
      chk({nm, ".rtData"}, bus.ex_rt_data, e.rtD);
      chk({nm, ".imm"}, bus.ex_imm, e.imm);
      chk({nm, ".rsAddr"}, {27'd0, bus.ex_rs_addr}, {27'd0, e.rs});
      chk({nm, ".rtAddr"}, {27'd0, bus.ex_rt_addr}, {27'd0, e.rt});
      chk({nm, ".rdAddr"}, {27'd0, bus.ex_rd_addr}, {27'd0, e.rd});
      chk({nm, ".cnt"}, {28'd0, stall_cnt}, {28'd0, e.cnt});
   endtask

   // Drive away from the edge, check comb stall, queue expectation,
   // then pop and compare just after the capturing edge.
   task automatic step(string nm, vec_t v, logic rv);
      exp_t e;
      @(negedge clk);
      drive(v);
      rst_n = rv;
      #1;
      chk({nm, ".stall"}, {31'd0, stall}, {31'd0, v.e.stall});
      sb.push_back(v.e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: scoreboard empty", nm);
      end else begin
         e = sb.pop_front();
         cmpEx(nm, e);
      end
   endtask

   idIn_t idle;
   idIn_t ldIn;
   idIn_t useIn;
   exp_t  zero;
   exp_t  ldExp;
   exp_t  bubExp;
   int    expCnt;

   initial begin
      checks   = 0;
      failures = 0;
      idle = mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
      zero = mkExp(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 4'd0);

      // in: v pc rs rt rd uRs uRt rsD rtD imm ctrl mr rw
      // exp: stall v mr rw ctrl pc rsD rtD imm rs rt rd cnt
      // plain capture
      tbl.push_back(mkVec(
         mkIn(1, 32'h40, 8, 9, 10, 1, 1, 32'h11, 32'h22,
              32'hFFFF_FFFC, 8'hA5, 0, 1), 0, 0, 0, 0, 0,
         mkExp(0, 1, 0, 1, 8'hA5, 32'h40, 32'h11, 32'h22,
               32'hFFFF_FFFC, 8, 9, 10, 4'd1 - 4'd1)));
      // lw r8
      tbl.push_back(mkVec(
         mkIn(1, 32'h44, 3, 0, 8, 1, 0, 32'h100, 0, 4, 8'h11, 1, 1),
         0, 0, 0, 0, 0,
         mkExp(0, 1, 1, 1, 8'h11, 32'h44, 32'h100, 0, 4, 3, 0, 8, 4'd0)));
      // use r8 via rs -> bubble
      tbl.push_back(mkVec(
         mkIn(1, 32'h48, 8, 9, 11, 1, 1, 32'h55, 32'h66, 0, 8'h22, 0, 1),
         0, 0, 0, 0, 0,
         mkExp(1, 0, 0, 0, 8'h00, 32'h44, 32'h100, 0, 4, 3, 0, 8, 4'd1)));
      // same ID instruction captures after the bubble
      tbl.push_back(mkVec(
         mkIn(1, 32'h48, 8, 9, 11, 1, 1, 32'h55, 32'h66, 0, 8'h22, 0, 1),
         0, 0, 0, 0, 0,
         mkExp(0, 1, 0, 1, 8'h22, 32'h48, 32'h55, 32'h66, 0, 8, 9, 11,
               4'd1)));
      // load with rd=0
      tbl.push_back(mkVec(
         mkIn(1, 32'h4C, 2, 0, 0, 1, 0, 7, 0, 8, 8'h33, 1, 1),
         0, 0, 0, 0, 0,
         mkExp(0, 1, 1, 1, 8'h33, 32'h4C, 7, 0, 8, 2, 0, 0, 4'd1)));
      // reads r0 behind load of r0: no hazard; itself a load of r12
      tbl.push_back(mkVec(
         mkIn(1, 32'h50, 0, 0, 12, 1, 1, 0, 0, 0, 8'h44, 1, 1),
         0, 0, 0, 0, 0,
         mkExp(0, 1, 1, 1, 8'h44, 32'h50, 0, 0, 0, 0, 0, 12, 4'd1)));
      // rt matches r12 but is not used
      tbl.push_back(mkVec(
         mkIn(1, 32'h54, 1, 12, 13, 1, 0, 9, 32'hA, 32'h10, 8'h55, 0, 1),
         0, 0, 0, 0, 0,
         mkExp(0, 1, 0, 1, 8'h55, 32'h54, 9, 32'hA, 32'h10, 1, 12, 13,
               4'd1)));
      // lw r14
      tbl.push_back(mkVec(
         mkIn(1, 32'h58, 1, 0, 14, 1, 0, 32'h20, 0, 0, 8'h66, 1, 1),
         0, 0, 0, 0, 0,
         mkExp(0, 1, 1, 1, 8'h66, 32'h58, 32'h20, 0, 0, 1, 0, 14, 4'd1)));
      // rt hazard on r14 with flush: flush wins, no count
      tbl.push_back(mkVec(
         mkIn(1, 32'h5C, 0, 14, 15, 0, 1, 1, 2, 3, 8'h77, 0, 1),
         0, 0, 0, 1, 0,
         mkExp(0, 0, 0, 0, 8'h00, 32'h58, 32'h20, 0, 0, 1, 0, 14, 4'd1)));
      // capture before hold
      tbl.push_back(mkVec(
         mkIn(1, 32'h60, 4, 5, 6, 1, 1, 32'h44, 32'h55, 32'h66, 8'h88, 0, 1),
         0, 0, 0, 0, 0,
         mkExp(0, 1, 0, 1, 8'h88, 32'h60, 32'h44, 32'h55, 32'h66, 4, 5, 6,
               4'd1)));
      // hold x3: frozen
      for (int i = 0; i < 3; i++)
         tbl.push_back(mkVec(
            mkIn(1, 32'h64, 7, 7, 7, 1, 1, 32'h1, 32'h2, 32'h3, 8'h99, 1, 1),
            0, 0, 0, 0, 1,
            mkExp(1, 1, 0, 1, 8'h88, 32'h60, 32'h44, 32'h55, 32'h66, 4, 5, 6,
                  4'd1)));
      // hold released
      tbl.push_back(mkVec(
         mkIn(1, 32'h64, 7, 7, 7, 1, 1, 32'h1, 32'h2, 32'h3, 8'h99, 0, 1),
         0, 0, 0, 0, 0,
         mkExp(0, 1, 0, 1, 8'h99, 32'h64, 32'h1, 32'h2, 32'h3, 7, 7, 7,
               4'd1)));
      // flush + hold: flush wins
      tbl.push_back(mkVec(
         mkIn(1, 32'h68, 1, 1, 1, 1, 1, 5, 5, 5, 8'hAA, 0, 1),
         0, 0, 0, 1, 1,
         mkExp(0, 0, 0, 0, 8'h00, 32'h64, 32'h1, 32'h2, 32'h3, 7, 7, 7,
               4'd1)));
      // write-back to r9 while ID reads rt=r9
      tbl.push_back(mkVec(
         mkIn(1, 32'h6C, 7, 9, 3, 1, 1, 32'h77, 0, 0, 8'h5A, 0, 1),
         1, 9, 32'hDEADBEEF, 0, 0,
         mkExp(0, 1, 0, 1, 8'h5A, 32'h6C, 32'h77, BYP_RT, 0, 7, 9, 3,
               4'd1)));
      // write-back to r0 never bypasses
      tbl.push_back(mkVec(
         mkIn(1, 32'h70, 0, 2, 4, 1, 1, 32'h5, 32'h12, 1, 8'h3C, 0, 1),
         1, 0, 32'hCAFEF00D, 0, 0,
         mkExp(0, 1, 0, 1, 8'h3C, 32'h70, 32'h5, 32'h12, 1, 0, 2, 4,
               4'd1)));
      // invalid ID: flags/ctrl forced to 0, data still loads
      tbl.push_back(mkVec(
         mkIn(0, 32'h74, 6, 7, 8, 1, 1, 32'hAB, 32'hCD, 32'hEF, 8'hFF, 1, 1),
         0, 0, 0, 0, 0,
         mkExp(0, 0, 0, 0, 8'h00, 32'h74, 32'hAB, 32'hCD, 32'hEF, 6, 7, 8,
               4'd1)));

      // reset state
      drive(mkVec(idle, 0, 0, 0, 0, 0, zero));
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      step("reset", mkVec(idle, 0, 0, 0, 0, 0, zero), 1'b0);

      foreach (tbl[i])
         step($sformatf("vec%0d", i), tbl[i], 1'b1);

      // 17 load-use bubbles with a 4-bit counter starting at 1
      ldIn   = mkIn(1, 32'h100, 1, 0, 8, 1, 0, 1, 0, 0, 8'h5A, 1, 1);
      useIn  = mkIn(1, 32'h104, 8, 0, 9, 1, 0, 2, 0, 0, 8'h21, 0, 1);
      ldExp  = mkExp(0, 1, 1, 1, 8'h5A, 32'h100, 1, 0, 0, 1, 0, 8, 4'd0);
      bubExp = mkExp(1, 0, 0, 0, 8'h00, 32'h100, 1, 0, 0, 1, 0, 8, 4'd0);
      expCnt = 1;
      for (int i = 0; i < 17; i++) begin
         ldExp.cnt = expCnt[3:0];
         step($sformatf("satLd%0d", i),
              mkVec(ldIn, 0, 0, 0, 0, 0, ldExp), 1'b1);
         expCnt = (expCnt >= 15) ? 15 : expCnt + 1;
         bubExp.cnt = expCnt[3:0];
         step($sformatf("satBub%0d", i),
              mkVec(useIn, 0, 0, 0, 0, 0, bubExp), 1'b1);
      end

      // hold over a load-use: frozen, no count
      ldExp.cnt = 4'hF;
      step("ldAgain", mkVec(ldIn, 0, 0, 0, 0, 0, ldExp), 1'b1);
      ldExp.stall = 1'b1;
      step("holdLU", mkVec(useIn, 0, 0, 0, 0, 1, ldExp), 1'b1);

      // reset mid-hold clears everything
      zero.stall = 1'b1;
      step("rstHold", mkVec(useIn, 0, 0, 0, 0, 1, zero), 1'b0);
      zero.stall = 1'b0;
      zero.v = 1'b1;
      zero.rw = 1'b1;
      zero.ctrl = 8'h21;
      zero.pc = 32'h104;
      zero.rsD = 2;
      zero.rs = 8;
      zero.rd = 9;
      step("postRst", mkVec(useIn, 0, 0, 0, 0, 0, zero), 1'b1);

      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard: %0d entries left", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the five-stage MIPS core, directly downstream of the register file. Captures RF read data, immediate, addresses and control for the EX stage. Detects load-use hazards against the instruction in EX and inserts a single bubble. Optionally bypasses same-cycle write-back data onto the RF read values.

## Interface
Parameters:
- CTRL_W, 8, width of the opaque EX/MEM/WB control bundle.
- CNT_W, 16, width of the load-use stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  32  PC of the ID instruction.
- id_rs_addr, id_rt_addr, id_rd_addr  in  5 each  source and destination register numbers.
- id_uses_rs, id_uses_rt  in  1 each  instruction actually reads rs/rt.
- id_rs_data, id_rt_data  in  32 each  RF read data (RsData/RtData).
- id_imm  in  32  sign/zero-extended immediate.
- id_ctrl  in  CTRL_W  control bundle.
- id_mem_read, id_reg_write  in  1 each  load / register-write flags.
- wb_reg_write, wb_rd_addr, wb_rd_data  in  1/5/32  write-back port, same signals driving RF RegWrite/RdAddr/RdData.
- flush  in  1  squash the ID instruction (taken branch/jump resolved in EX).
- hold  in  1  downstream freeze (multi-cycle memory).
- stall  out  1  freeze PC and IF/ID this cycle (combinational).
- ex_valid, ex_mem_read, ex_reg_write  out  1 each  registered flags.
- ex_pc, ex_rs_data, ex_rt_data, ex_imm  out  32 each  registered.
- ex_rs_addr, ex_rt_addr, ex_rd_addr  out  5 each  registered.
- ex_ctrl  out  CTRL_W  registered.
- stall_cnt  out  CNT_W  saturating count of load-use bubbles.

## Operation
- load_use = id_valid & ex_valid & ex_mem_read & (ex_rd_addr != 0) & ((id_uses_rs & id_rs_addr == ex_rd_addr) | (id_uses_rt & id_rt_addr == ex_rd_addr)).
- stall = ~flush & (hold | load_use).
- Per-edge priority, highest first:
  - rst_n=0: every output register cleared to 0, stall_cnt=0.
  - flush=1: ex_valid, ex_mem_read, ex_reg_write, ex_ctrl <= 0. Data and address fields hold their values.
  - hold=1: all EX registers hold.
  - load_use=1: bubble inserted (same clearing as flush). stall_cnt increments, saturating at all-ones.
  - Otherwise: load all ex_* from id_*, with ex_valid <= id_valid. If id_valid=0, ex_mem_read, ex_reg_write and ex_ctrl are loaded as 0.
- stall_cnt changes only on load-use bubble cycles. It does not count hold or flush cycles.
- Register 0 never bypasses and never triggers load_use.

## Timing
- Capture latency: 1 cycle from ID inputs to ex_* outputs.
- Load-use stall lasts exactly one cycle, because the bubble clears ex_valid. The next cycle recomputes RF data, and the loaded value arrives later via the team's EX forwarding.
- hold may persist any number of cycles. stall stays high throughout and outputs stay frozen.
- flush together with load_use or hold: flush wins, stall=0, bubble inserted, stall_cnt unchanged.
- Reset asserted mid-hold or mid-stall: outputs are 0 on the following edge and stall_cnt clears. stall depends only on current inputs and the cleared ex_valid.

## Configuration
- WB_BYPASS_EN defined:
  - Captured rs data = id_rs_data replaced by wb_rd_data when wb_reg_write & wb_rd_addr != 0 & wb_rd_addr == id_rs_addr.
  - rt data uses the same rule with id_rt_addr.
  - This covers the RF posedge-write/same-cycle-read gap.
- WB_BYPASS_EN undefined: id_rs_data/id_rt_data are captured unmodified. Write-back in the same cycle as the ID read is then the pipeline controller's responsibility.

## Test plan
- Plain capture: id_valid=1, pc=0x40, rs=8 data 0x11, rt=9 data 0x22, imm=0xFFFFFFFC -> next cycle ex_valid=1 with identical fields, stall=0.
- Load-use: EX holds lw with rd=8, ID reads rs=8 with id_uses_rs=1 -> stall=1 one cycle, then ex_valid=0, ex_mem_read=0, stall_cnt=1. Next cycle stall=0 and the instruction captures.
- Load with rd=0, or id_uses_rt=0 with rt matching -> no stall, stall_cnt unchanged.
- Flush during load-use -> stall=0, ex_valid=0 next cycle, stall_cnt unchanged. hold=1 for 3 cycles -> stall=1 and ex_* frozen for 3 cycles.
- WB bypass: wb_reg_write=1, wb_rd_addr=9, wb_rd_data=0xDEADBEEF, id_rt_addr=9, id_rt_data=0x0 -> ex_rt_data=0xDEADBEEF with WB_BYPASS_EN, 0x0 without. wb_rd_addr=0 never bypasses.
- Saturation and reset: force CNT_W=4 with 17 bubbles -> stall_cnt=0xF. Then rst_n=0 for one cycle -> all outputs 0.
